// File: rtl/demux_1_a_2.sv
// rtl/demux_1_a_2.sv - 1-to-2 ready/valid demultiplexer with one-entry holding register per channel.
// Optional macro DEMUX_CONTADORES_EN adds per-channel 8-bit output-transfer counters.
module demux_1_a_2 #(
  parameter int ANCHO = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             seleccion_i,
  input  logic [ANCHO-1:0] entrada_i,
  input  logic             valido_i,
  output logic             listo_o,
  output logic [ANCHO-1:0] salida0_o,
  output logic [ANCHO-1:0] salida1_o,
  output logic             valido0_o,
  output logic             valido1_o,
`ifdef DEMUX_CONTADORES_EN
  output logic [7:0]       cuenta0_o,
  output logic [7:0]       cuenta1_o,
`endif
  input  logic             listo0_i,
  input  logic             listo1_i
);

  typedef enum logic {VACIO = 1'b0, LLENO = 1'b1} estado_t;

  estado_t          r_estado0, r_estado1;
  logic [ANCHO-1:0] r_dato0, r_dato1;

  logic w_sal0, w_sal1;
  logic w_ent0, w_ent1;
  logic w_listo;

  assign w_sal0 = (r_estado0 == LLENO) && listo0_i;
  assign w_sal1 = (r_estado1 == LLENO) && listo1_i;

  // Only the addressed channel gates acceptance; the other may be stalled.
  assign w_listo = seleccion_i ? ((r_estado1 == VACIO) || listo1_i)
                               : ((r_estado0 == VACIO) || listo0_i);

  assign w_ent0 = valido_i && w_listo && !seleccion_i;
  assign w_ent1 = valido_i && w_listo &&  seleccion_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_estado0 <= VACIO;
      r_dato0   <= '0;
    end else begin
      case (r_estado0)
        VACIO: if (w_ent0) begin
          r_estado0 <= LLENO;
          r_dato0   <= entrada_i;
        end
        LLENO: if (w_ent0) begin
          r_dato0   <= entrada_i;
        end else if (w_sal0) begin
          r_estado0 <= VACIO;
        end
        default: r_estado0 <= VACIO;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_estado1 <= VACIO;
      r_dato1   <= '0;
    end else begin
      case (r_estado1)
        VACIO: if (w_ent1) begin
          r_estado1 <= LLENO;
          r_dato1   <= entrada_i;
        end
        LLENO: if (w_ent1) begin
          r_dato1   <= entrada_i;
        end else if (w_sal1) begin
          r_estado1 <= VACIO;
        end
        default: r_estado1 <= VACIO;
      endcase
    end
  end

  assign listo_o   = w_listo;
  assign salida0_o = r_dato0;
  assign salida1_o = r_dato1;
  assign valido0_o = (r_estado0 == LLENO);
  assign valido1_o = (r_estado1 == LLENO);

`ifdef DEMUX_CONTADORES_EN
  logic [7:0] r_cuenta0, r_cuenta1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cuenta0 <= 8'd0;
      r_cuenta1 <= 8'd0;
    end else begin
      if (w_sal0) r_cuenta0 <= r_cuenta0 + 8'd1;
      if (w_sal1) r_cuenta1 <= r_cuenta1 + 8'd1;
    end
  end

  assign cuenta0_o = r_cuenta0;
  assign cuenta1_o = r_cuenta1;
`endif

endmodule

// File: tb/tb_demux_1_a_2.sv
// tb/tb_demux_1_a_2.sv - scoreboard bench for demux_1_a_2 (honours DEMUX_CONTADORES_EN when defined).
module tb_demux_1_a_2;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       seleccion_i;
  logic [7:0] entrada_i;
  logic       valido_i;
  logic       listo_o;
  logic [7:0] salida0_o, salida1_o;
  logic       valido0_o, valido1_o;
  logic       listo0_i, listo1_i;
`ifdef DEMUX_CONTADORES_EN
  logic [7:0] cuenta0_o, cuenta1_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n0 = 0;
  int n1 = 0;

  always #5 clk = ~clk;

  demux_1_a_2 #(.ANCHO(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .seleccion_i (seleccion_i),
    .entrada_i   (entrada_i),
    .valido_i    (valido_i),
    .listo_o     (listo_o),
    .salida0_o   (salida0_o),
    .salida1_o   (salida1_o),
    .valido0_o   (valido0_o),
    .valido1_o   (valido1_o),
`ifdef DEMUX_CONTADORES_EN
    .cuenta0_o   (cuenta0_o),
    .cuenta1_o   (cuenta1_o),
`endif
    .listo0_i    (listo0_i),
    .listo1_i    (listo1_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the falling edge, check outputs, then advance the model at the rising edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic l0, input logic l1);
    logic exp_listo;
    @(negedge clk);
    valido_i = v; seleccion_i = s; entrada_i = d; listo0_i = l0; listo1_i = l1;
    #1;
    chk("valido0", {31'd0, valido0_o}, {31'd0, q0.size() != 0});
    chk("valido1", {31'd0, valido1_o}, {31'd0, q1.size() != 0});
    if (q0.size() != 0) chk("salida0", {24'd0, salida0_o}, {24'd0, q0[0]});
    if (q1.size() != 0) chk("salida1", {24'd0, salida1_o}, {24'd0, q1[0]});
    exp_listo = s ? (q1.size() == 0 || l1) : (q0.size() == 0 || l0);
    chk("listo", {31'd0, listo_o}, {31'd0, exp_listo});
    @(posedge clk);
    if (q0.size() != 0 && l0) begin void'(q0.pop_front()); n0++; end
    if (q1.size() != 0 && l1) begin void'(q1.pop_front()); n1++; end
    if (v && exp_listo) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    valido_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_valido0", {31'd0, valido0_o}, 32'd0);
    chk("rst_valido1", {31'd0, valido1_o}, 32'd0);
    chk("rst_salida0", {24'd0, salida0_o}, 32'd0);
    chk("rst_salida1", {24'd0, salida1_o}, 32'd0);
    q0.delete(); q1.delete(); n0 = 0; n1 = 0;
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  initial begin
    rst_n_i = 1'b0; valido_i = 1'b0; seleccion_i = 1'b0; entrada_i = 8'd0;
    listo0_i = 1'b1; listo1_i = 1'b1;
    do_reset();

    // basic routing
    step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // backpressure on channel 0
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // channel 0 stalled full, channel 1 still flows; selector toggles while idle
    step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0);

    // both full, then reset mid-operation
    step(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // streaming, alternating channels
    for (int i = 0; i < 16; i++)
      step(1'b1, i[0], 8'h80 + 8'(i), 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // random traffic with random backpressure
    for (int i = 0; i < 60; i++)
      step(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

`ifdef DEMUX_CONTADORES_EN
    do_reset();
    for (int i = 0; i < 257; i++)
      step(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    chk("cuenta1", {24'd0, cuenta1_o}, 32'd1);
    chk("cuenta0", {24'd0, cuenta0_o}, 32'd0);
    chk("cuenta1_model", {24'd0, cuenta1_o}, 32'(n1 % 256));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1_a_2.md
DEMUX_1_A_2 -- requirements
Module: demux_1_a_2

Interface
REQ-001 Parameter ANCHO, default 8, data width in bits of the input and both output channels.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 seleccion_i  input  1  destination channel for the current input word (0 -> channel 0, 1 -> channel 1).
REQ-005 entrada_i  input  ANCHO  input data word.
REQ-006 valido_i  input  1  input word and seleccion_i are valid.
REQ-007 listo_o  output  1  block accepts the input word this cycle.
REQ-008 salida0_o / salida1_o  output  ANCHO each  registered data for channel 0 / channel 1.
REQ-009 valido0_o / valido1_o  output  1 each  channel 0 / channel 1 holds a valid word.
REQ-010 listo0_i / listo1_i  input  1 each  downstream of channel 0 / channel 1 accepts its word.

Function
REQ-011 Input transfer occurs in a cycle where valido_i=1 and listo_o=1; output transfer k occurs where valido_k_o=1 and listo_k_i=1.
REQ-012 Each channel SHALL have a one-entry holding register with two states: VACIO (valido_k_o=0) and LLENO (valido_k_o=1).
REQ-013 listo_o SHALL be combinational: 1 when the channel addressed by seleccion_i is VACIO, or is LLENO with listo_k_i=1 in the same cycle; else 0.
REQ-014 listo_o SHALL NOT depend on the state or listo_k_i of the non-addressed channel.
REQ-015 On input transfer to channel k, entrada_i SHALL be captured into salida_k_o and channel k SHALL be LLENO at the next edge (latency 1 cycle).
REQ-016 VACIO -> LLENO: input transfer to k; LLENO -> VACIO: output transfer on k with no input transfer to k; LLENO -> LLENO with new data: output transfer and input transfer to k in the same cycle.
REQ-017 LLENO with listo_k_i=0: salida_k_o and valido_k_o SHALL hold stable until the output transfer.
REQ-018 Channels SHALL operate independently: a stall on one channel SHALL NOT block transfers to the other.
REQ-019 Data SHALL be passed unmodified; no word SHALL be dropped or duplicated; order per channel SHALL be preserved.
REQ-020 When valido_i=0, no channel register SHALL change except by its own output transfer.
REQ-021 Changes of seleccion_i while valido_i=0 SHALL have no effect.

Reset
REQ-022 While rst_n_i=0: valido0_o=0, valido1_o=0, salida0_o=0, salida1_o=0, both channels VACIO, asynchronously.
REQ-023 Reset asserted mid-operation SHALL discard held words; after release the first accepted word SHALL appear normally one cycle later.
REQ-024 listo_o SHALL be 1 in the first cycle after reset release (both channels VACIO).

Configuration
REQ-025 Macro DEMUX_CONTADORES_EN: when defined, outputs cuenta0_o and cuenta1_o (8 bits each) SHALL count output transfers on channel 0 / channel 1, wrapping 255 -> 0, reset to 0.
REQ-026 Without DEMUX_CONTADORES_EN the ports cuenta0_o/cuenta1_o and their logic SHALL not exist; all other behaviour identical.

Verification
REQ-027 Reset: rst_n_i=0 mid-transfer with both channels LLENO -> valido0_o=0, valido1_o=0, salidas=0 immediately, listo_o=1 after release.
REQ-028 Basic routing: ANCHO=8, send 0xA5 sel=0 then 0x3C sel=1, listo0_i=listo1_i=1 -> salida0_o=0xA5 one cycle after first accept, salida1_o=0x3C one cycle after second.
REQ-029 Backpressure: listo0_i=0, send 0x11 then 0x22 to channel 0 -> second cycle listo_o=0, salida0_o holds 0x11; raise listo0_i -> 0x22 accepted same cycle, appears next cycle.
REQ-030 Independence: channel 0 stalled LLENO, send 0x77 sel=1 -> listo_o=1, salida1_o=0x77 next cycle.
REQ-031 Streaming: 16 back-to-back words alternating sel, both listo=1 -> listo_o constantly 1, each channel receives its 8 words in order, no gaps beyond 1-cycle latency.
REQ-032 With DEMUX_CONTADORES_EN: 257 transfers on channel 1 -> cuenta1_o=1, cuenta0_o=0.
